// File: rtl/pipe_pkg.sv
// Shared widths and stage-entry layout for the bypass result pipeline.
package pipe_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 64;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic                          v;
    logic [DEF_REG_ADDR_WIDTH-1:0] rd;
    logic                          we;
    logic                          pend;
    logic [DEF_DATA_WIDTH-1:0]     data;
  } pipe_entry_t;

endpackage

// File: rtl/bypass_pipe_if.sv
// Issue/bypass/writeback bundle between decode/ALU, the result pipe and the register file.
interface bypass_pipe_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
);

  logic                      in_valid;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic                      in_we;
  logic                      in_pending;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      stall;
  logic                      flush;
  logic                      ld_fill_valid;
  logic [DATA_WIDTH-1:0]     ld_fill_data;
  logic [REG_ADDR_WIDTH-1:0] ra;
  logic [REG_ADDR_WIDTH-1:0] rb;
  logic                      fwd_a_hit;
  logic                      fwd_b_hit;
  logic [DATA_WIDTH-1:0]     fwd_a_data;
  logic [DATA_WIDTH-1:0]     fwd_b_data;
  logic                      stall_req;
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      err_unfilled;

  modport master (
    output in_valid, in_rd, in_we, in_pending, in_data,
    output stall, flush, ld_fill_valid, ld_fill_data, ra, rb,
    input  fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, stall_req,
    input  wb_valid, wb_rd, wb_data, err_unfilled
  );

  modport slave (
    input  in_valid, in_rd, in_we, in_pending, in_data,
    input  stall, flush, ld_fill_valid, ld_fill_data, ra, rb,
    output fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, stall_req,
    output wb_valid, wb_rd, wb_data, err_unfilled
  );

endinterface

// File: rtl/bypass_lookup.sv
// Youngest-first priority match of one source operand against the result stages.
module bypass_lookup
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned DEPTH          = 2
) (
  input  logic                      v_i    [DEPTH],
  input  logic                      we_i   [DEPTH],
  input  logic                      pend_i [DEPTH],
  input  logic [REG_ADDR_WIDTH-1:0] rd_i   [DEPTH],
  input  logic [DATA_WIDTH-1:0]     data_i [DEPTH],
  input  logic [REG_ADDR_WIDTH-1:0] addr_i,
  output logic                      match_c_o,
  output logic                      pend_c_o,
  output logic [DATA_WIDTH-1:0]     data_c_o
);

  always_comb begin
    match_c_o = 1'b0;
    pend_c_o  = 1'b0;
    data_c_o  = '0;
    // Oldest first, so a younger match overwrites any older one.
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (v_i[k] && we_i[k] && (rd_i[k] == addr_i)) begin
        match_c_o = 1'b1;
        pend_c_o  = pend_i[k];
        data_c_o  = data_i[k];
      end
    end
  end

endmodule

// File: rtl/bypass_pipe.sv
// DEPTH-stage result pipeline with in-place load fill and two-port bypass lookup.
// BYPASS_FWD_EN enables forwarding; without it any in-flight match is a full interlock.
module bypass_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned LOAD_STAGE     = 1,
  parameter int unsigned FLUSH_STAGES   = 1
) (
  input  logic          clk,
  input  logic          rst,
  bypass_pipe_if.slave  bus
);

  typedef struct packed {
    logic                      v;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      we;
    logic                      pend;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  localparam int unsigned LAST      = DEPTH - 1;
  localparam int unsigned LOAD_IDX  = LOAD_STAGE - 1;
  localparam int unsigned FILL_NEXT = (LOAD_STAGE < DEPTH) ? LOAD_STAGE : DEPTH - 1;

  entry_t stage_q [DEPTH];
  entry_t stage_d [DEPTH];
  entry_t live_c  [DEPTH];
  entry_t in_entry_c;
  logic   fill_hit_c;
  logic   err_q;
  logic   err_d;

  logic                      v_c    [DEPTH];
  logic                      we_c   [DEPTH];
  logic                      pend_c [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_c   [DEPTH];
  logic [DATA_WIDTH-1:0]     data_c [DEPTH];

  logic                  a_match_c, a_pend_c;
  logic                  b_match_c, b_pend_c;
  logic [DATA_WIDTH-1:0] a_data_c, b_data_c;

  // Next-state: kill flushed entries in place, then shift or hold, then land the fill.
  always_comb begin
    live_c = stage_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (bus.flush && (k < FLUSH_STAGES)) live_c[k].v = 1'b0;
    end

    in_entry_c = '{v:    bus.in_valid & ~bus.flush,
                   rd:   bus.in_rd,
                   we:   bus.in_we,
                   pend: bus.in_pending,
                   data: bus.in_pending ? '0 : bus.in_data};

    stage_d = live_c;
    if (!bus.stall) begin
      stage_d[0] = in_entry_c;
      for (int unsigned k = 1; k < DEPTH; k++) stage_d[k] = live_c[k-1];
    end

    // The fill follows its entry: same slot under stall, next slot on advance.
    fill_hit_c = bus.ld_fill_valid & live_c[LOAD_IDX].v & live_c[LOAD_IDX].pend;
    if (fill_hit_c) begin
      if (bus.stall) begin
        stage_d[LOAD_IDX].data = bus.ld_fill_data;
        stage_d[LOAD_IDX].pend = 1'b0;
      end else if (LOAD_STAGE < DEPTH) begin
        stage_d[FILL_NEXT].data = bus.ld_fill_data;
        stage_d[FILL_NEXT].pend = 1'b0;
      end
    end

    err_d = err_q | (stage_q[LAST].v & stage_q[LAST].we & stage_q[LAST].pend & ~bus.stall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      err_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      v_c[k]    = stage_q[k].v;
      we_c[k]   = stage_q[k].we;
      pend_c[k] = stage_q[k].pend;
      rd_c[k]   = stage_q[k].rd;
      data_c[k] = stage_q[k].data;
    end
  end

  bypass_lookup #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .DEPTH(DEPTH)
  ) u_lookup_a (
    .v_i(v_c), .we_i(we_c), .pend_i(pend_c), .rd_i(rd_c), .data_i(data_c),
    .addr_i(bus.ra), .match_c_o(a_match_c), .pend_c_o(a_pend_c), .data_c_o(a_data_c)
  );

  bypass_lookup #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .DEPTH(DEPTH)
  ) u_lookup_b (
    .v_i(v_c), .we_i(we_c), .pend_i(pend_c), .rd_i(rd_c), .data_i(data_c),
    .addr_i(bus.rb), .match_c_o(b_match_c), .pend_c_o(b_pend_c), .data_c_o(b_data_c)
  );

`ifdef BYPASS_FWD_EN
  assign bus.fwd_a_hit  = a_match_c & ~a_pend_c;
  assign bus.fwd_b_hit  = b_match_c & ~b_pend_c;
  assign bus.fwd_a_data = a_data_c;
  assign bus.fwd_b_data = b_data_c;
  assign bus.stall_req  = (a_match_c & a_pend_c) | (b_match_c & b_pend_c);
`else
  logic unused_fwd_c;
  assign unused_fwd_c   = ^{a_pend_c, b_pend_c, a_data_c, b_data_c};
  assign bus.fwd_a_hit  = 1'b0;
  assign bus.fwd_b_hit  = 1'b0;
  assign bus.fwd_a_data = '0;
  assign bus.fwd_b_data = '0;
  assign bus.stall_req  = a_match_c | b_match_c;
`endif

  // Stalled cycles suppress the write so a held entry is not written twice.
  assign bus.wb_valid     = stage_q[LAST].v & stage_q[LAST].we & ~stage_q[LAST].pend & ~bus.stall;
  assign bus.wb_rd        = stage_q[LAST].rd;
  assign bus.wb_data      = stage_q[LAST].data;
  assign bus.err_unfilled = err_q;

endmodule

// File: doc/bypass_pipe.md
Name: bypass_pipe

Overview:
- Parametrised result pipeline with a bypass network; successor to the fixed 3-stage EXE/WB register chain and single-source forwarding mux in the core pipeline.
- Carries issued results (rd, write enable, data, load-pending flag) through DEPTH stages to the register-file write port.
- Serves two source-operand lookups from the youngest matching stage, and raises a stall request when the match is a load whose data has not yet arrived.
- Sits between decode/ALU and the register file; the dmem/NIC load return fills pending entries in place.

Parameters:
- DATA_WIDTH, 64, result/operand width.
- REG_ADDR_WIDTH, 5, register address width.
- DEPTH, 2, number of result stages (>=1).
- LOAD_STAGE, 1, stage index (1..DEPTH) where load data is filled.
- FLUSH_STAGES, 1, number of youngest stages (1..DEPTH) cleared by flush.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  new result entry offered
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_we  in  1  entry writes the register file
- in_pending  in  1  entry is a load; data arrives later
- in_data  in  DATA_WIDTH  ALU result (ignored when in_pending)
- stall  in  1  freeze all stages
- flush  in  1  kill youngest FLUSH_STAGES entries
- ld_fill_valid  in  1  load data valid
- ld_fill_data  in  DATA_WIDTH  load data (dmem or NIC)
- ra, rb  in  REG_ADDR_WIDTH  source operand addresses
- fwd_a_hit, fwd_b_hit  out  1  operand served by the bypass
- fwd_a_data, fwd_b_data  out  DATA_WIDTH  bypass data
- stall_req  out  1  a matched entry is still pending
- wb_valid  out  1  register-file write this cycle
- wb_rd  out  REG_ADDR_WIDTH  write address
- wb_data  out  DATA_WIDTH  write data
- err_unfilled  out  1  sticky: a pending entry reached writeback unfilled

Behaviour:
- Reset (asynchronous, rst=1):
  - All stage valid bits cleared.
  - All outputs 0, including err_unfilled.
- Stage k (1..DEPTH) holds {v, rd, we, pend, data}.
- Advance (stall=0), each posedge:
  - Stage1 <= input entry, with v=in_valid.
  - Stage k <= stage k-1.
  - Stage DEPTH is retired.
- stall=1: every stage holds its contents; the input entry is not accepted.
- flush=1:
  - Stages 1..FLUSH_STAGES get v=0 at the edge, whether or not stall is asserted.
  - An input offered in the same cycle is dropped.
  - Older stages advance or hold as normal.
  - Flush wins over fill for a killed entry.
- Fill:
  - When ld_fill_valid=1 and stage LOAD_STAGE has v=1 and pend=1, that stage's data <= ld_fill_data and pend <= 0.
  - The fill lands in the entry's next position, so it applies across an advance as well as during a stall.
  - In all other cases the fill is ignored.
- Writeback (combinational from stage DEPTH):
  - wb_valid = v & we & ~pend; wb_rd and wb_data come from stage DEPTH.
  - wb_valid is forced to 0 while stall=1, so there are no duplicate writes.
- Latency: an entry accepted at edge t appears on wb_* during the cycle after edge t+DEPTH-1.
- Unfilled load: if stage DEPTH has v & we & pend while not stalled, wb_valid=0 and err_unfilled sets; it clears only on rst.
- Forwarding (combinational):
  - For each port, find the lowest-index stage with v & we & rd==ra (resp. rb).
  - On a match: hit=1 and data=stage data.
  - If the matched stage has pend=1, hit=0 and stall_req=1.
  - No match: hit=0, data=0.
  - Older matches never override a younger match.
  - Register 0 is treated like any other register.
- stall_req = OR of the pending matches on the A and B ports.

Optional Feature:
- Macro: BYPASS_FWD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - fwd_*_hit and fwd_*_data are tied to 0.
  - Any valid, write-enabled match on ra or rb in any stage asserts stall_req, pending or not: a full interlock.
  - Fill and writeback behaviour is unchanged.

Decomposition:
- Shared package pipe_pkg:
  - Stage-entry struct typedef {v, rd, we, pend, data}.
  - DATA_WIDTH and REG_ADDR_WIDTH defaults.
- One sub-module: bypass_lookup, a combinational youngest-match priority select, instantiated once per source port.

Test Plan:
- DEPTH=2: issue rd=3, we=1, data=0x55 at edge 1 with ra=3 → fwd_a_hit=1, fwd_a_data=0x55 during cycle 1-2; wb_valid=1, wb_rd=3, wb_data=0x55 after edge 2.
- Back-to-back rd=4/0x11 then rd=4/0x22, rb=4 → fwd_b_data=0x22 (younger wins) while both are in flight.
- Load rd=7 pending, ra=7 → stall_req=1, fwd_a_hit=0; assert stall. Then ld_fill_valid=1, data=0xABCD → next cycle stall_req=0, fwd_a_data=0xABCD; writeback later carries 0xABCD.
- flush=1 with stage1 holding rd=9 and an offered input rd=10 → neither ever writes back; the stage2 entry retires normally.
- Pending entry never filled reaches stage DEPTH → wb_valid=0, err_unfilled=1 and sticky; rst mid-stream → all valid bits, outputs and err_unfilled are 0 immediately, with no clock edge.
- BYPASS_FWD_EN undefined: ALU result rd=5 in flight, ra=5 → stall_req=1, fwd_a_hit=0.
